// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer: IDLE -> DECODE -> EXEC -> (MEM_WAIT) -> WB.
// Optional LOAD watchdog enabled by defining CU_MEM_TIMEOUT_EN.
module seq_control_unit #(
  parameter int INSTR_W     = 16,
  parameter int REG_AW      = 2,
  parameter int ADDR_W      = 8,
  parameter int ALU_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               branch_check,
  input  logic               mem_ready,
  output logic [ALU_W-1:0]   alu_code,
  output logic               ram_rd,
  output logic               reg_rd,
  output logic               reg_wr,
  output logic               pc_jump,
  output logic               pc_branch,
  output logic [REG_AW-1:0]  reg1,
  output logic [REG_AW-1:0]  reg2,
  output logic [ADDR_W-1:0]  ram_adr,
  output logic               illegal,
  output logic               mem_timeout,
  output logic               busy,
  output logic [15:0]        retired
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_LOAD = 4'b0100;
  localparam logic [3:0] OP_JUMP = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_WB       = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [15:0]        retired_q, retired_d;

  logic [3:0]         opcode_s;
  logic [REG_AW-1:0]  rs1_s, rs2_s;
  logic [ADDR_W-1:0]  adr_s;
  logic               is_alu_s, is_load_s, is_jump_s, is_branch_s, is_legal_s;
  logic               tmo_hit_s;

  assign opcode_s    = ir_q[INSTR_W-1 -: 4];
  assign rs1_s       = ir_q[INSTR_W-5 -: REG_AW];
  assign rs2_s       = ir_q[INSTR_W-5-REG_AW -: REG_AW];
  assign adr_s       = ir_q[ADDR_W-1:0];
  assign is_alu_s    = (opcode_s == OP_ADD) || (opcode_s == OP_SUB);
  assign is_load_s   = (opcode_s == OP_LOAD);
  assign is_jump_s   = (opcode_s == OP_JUMP);
  assign is_branch_s = (opcode_s == 4'b1101) || (opcode_s == 4'b1110) || (opcode_s == 4'b1111);
  assign is_legal_s  = is_alu_s || is_load_s || is_jump_s || is_branch_s;

`ifdef CU_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // EXEC precedes every MEM_WAIT entry, so clearing there restarts the count.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_EXEC) begin
      tmo_d = '0;
    end else if (state_q == S_MEM_WAIT) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit_s = (state_q == S_MEM_WAIT) && !mem_ready &&
                     (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
`else
  logic unused_tmo_s;
  assign unused_tmo_s = MEM_TIMEOUT[0];
  assign tmo_hit_s    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instruction;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
        if (is_legal_s) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (is_alu_s) begin
          state_d = S_WB;
        end else if (is_load_s) begin
          state_d = S_MEM_WAIT;
        end else begin
          state_d   = S_IDLE;
          retired_d = retired_q + 16'd1;
        end
      end
      S_MEM_WAIT: begin
        // mem_ready takes priority over a timeout reached in the same cycle
        if (mem_ready) begin
          state_d = S_WB;
        end else if (tmo_hit_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_MEM_WAIT;
        end
      end
      S_WB: begin
        state_d   = S_IDLE;
        retired_d = retired_q + 16'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    alu_code    = '0;
    ram_rd      = 1'b0;
    reg_rd      = 1'b0;
    reg_wr      = 1'b0;
    pc_jump     = 1'b0;
    pc_branch   = 1'b0;
    reg1        = '0;
    reg2        = '0;
    ram_adr     = '0;
    illegal     = 1'b0;
    mem_timeout = tmo_hit_s;
    busy        = (state_q != S_IDLE);
    retired     = retired_q;
    case (state_q)
      S_IDLE: begin
        instr_ready = !rst;
      end
      S_DECODE: begin
        reg_rd  = 1'b1;
        illegal = !is_legal_s;
        if (is_alu_s || is_branch_s) begin
          reg1 = rs1_s;
          reg2 = rs2_s;
        end else if (is_load_s) begin
          reg1 = rs1_s;
        end else begin
          reg1 = '0;
        end
      end
      S_EXEC: begin
        if (is_alu_s) begin
          alu_code = (opcode_s == OP_ADD) ? ALU_W'(4'b1000) : ALU_W'(4'b0100);
          reg1     = rs1_s;
          reg2     = rs2_s;
        end else if (is_load_s) begin
          alu_code = ALU_W'(4'b1001);
          ram_rd   = 1'b1;
          ram_adr  = adr_s;
        end else if (is_jump_s) begin
          pc_jump = 1'b1;
          ram_adr = adr_s;
        end else begin
          alu_code  = ALU_W'(opcode_s);
          reg1      = rs1_s;
          reg2      = rs2_s;
          pc_branch = branch_check;
          ram_adr   = branch_check ? adr_s : '0;
        end
      end
      S_MEM_WAIT: begin
        ram_rd  = 1'b1;
        ram_adr = adr_s;
        reg1    = rs1_s;
      end
      S_WB: begin
        reg_wr = 1'b1;
        reg1   = rs1_s;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule
